// File: rtl/rv_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the core's decoder.
package rv_pkg;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Byte loads use the zero-extending encoding (100) that the decoder expects.
    localparam logic [2:0] F3_LB = 3'b100;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_IMM    = 2'd2
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // True when a 32-bit immediate is the sign extension of its low 12 bits.
    function automatic logic imm_fits_12(input logic [31:0] imm);
        return (&imm[31:11]) || !(|imm[31:11]);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded RV32I fields in, 32-bit instruction word and error code out.
module instr_pack
    import rv_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic        byte_flag_i,
    output logic [31:0] word_o,
    output err_code_e   err_code_o
);

    logic imm_i_ok;
    logic imm_u_ok;
    logic [2:0] load_f3;
    logic [2:0] store_f3;

    assign imm_i_ok = imm_fits_12(imm_i);
    assign imm_u_ok = (imm_i[11:0] == 12'd0);
    assign load_f3  = byte_flag_i ? F3_LB : F3_LW;
    assign store_f3 = byte_flag_i ? F3_SB : F3_SW;

    always_comb begin
        word_o     = '0;
        err_code_o = ERR_NONE;
        case (opcode_i)
            OPC_OPIMM, OPC_JALR: begin
                word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                if (!imm_i_ok) err_code_o = ERR_IMM;
            end
            OPC_OP: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            OPC_LUI: begin
                word_o = {imm_i[31:12], rd_i, opcode_i};
                if (!imm_u_ok) err_code_o = ERR_IMM;
            end
            OPC_LOAD: begin
                word_o = {imm_i[11:0], rs1_i, load_f3, rd_i, opcode_i};
                if (!imm_i_ok) err_code_o = ERR_IMM;
            end
            OPC_STORE: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, store_f3, imm_i[4:0], opcode_i};
                if (!imm_i_ok) err_code_o = ERR_IMM;
            end
            default: begin
                err_code_o = ERR_OPCODE;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Stream-to-memory instruction encoder: packs accepted field tuples into RV32I words
// and writes them to consecutive word addresses until the memory is full.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic              in_byte_flag,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              err_q;
    err_code_e         err_code_q;
    logic [ADDR_W:0]   count_q;

    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   count_d;
    logic              write_fire;
    logic              fill_last;
    logic              accept;
    logic              take;
    logic [31:0]       pack_word;
    err_code_e         pack_err;

    instr_pack u_pack (
        .opcode_i    (in_opcode),
        .rd_i        (in_rd),
        .rs1_i       (in_rs1),
        .rs2_i       (in_rs2),
        .imm_i       (in_imm),
        .funct3_i    (in_funct3),
        .funct7_i    (in_funct7),
        .byte_flag_i (in_byte_flag),
        .word_o      (pack_word),
        .err_code_o  (pack_err)
    );

    assign in_ready   = (state_q == ST_RUN) && !start && (!mem_we_q || mem_ready);
    assign accept     = in_valid && in_ready;
    assign write_fire = mem_we_q && mem_ready;
    assign addr_d     = mem_addr_q + 1'b1;
    assign count_d    = count_q + 1'b1;
    assign fill_last  = write_fire && (count_d == CAPACITY);
    // A tuple accepted alongside the final write has nowhere to go; it is consumed and dropped.
    assign take       = accept && !fill_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            count_q     <= '0;
        end else if (start) begin
            state_q    <= ST_RUN;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (write_fire) begin
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= addr_d;
                        count_q    <= count_d;
                    end
                    if (take) begin
                        if (pack_err == ERR_NONE) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= pack_word;
                        end else if (!err_q) begin
                            err_q      <= 1'b1;
                            err_code_q <= pack_err;
                        end
                    end
                    if (fill_last) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_IDLE, ST_FULL: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign count     = count_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_FULL);

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the core's instruction decoder: accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit RV32I words. Writes each word to instruction memory at an auto-incrementing word address. Used by the on-chip program loader and by self-checking benches to build programs that the decoder then consumes. Supported opcodes: OP-IMM (0010011), JALR (1100111), OP (0110011), LUI (0110111), LOAD (0000011) and STORE (0100011).

Parameters:
ADDR_W, 8, word-address width; capacity is 2**ADDR_W words
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a new program at BASE_ADDR and clears count and error
in_valid  input  1  field tuple valid
in_ready  output  1  encoder can accept a tuple this cycle
in_opcode  input  7  opcode
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  immediate, in the same form the decoder produces (sign-extended I/S, U already shifted left by 12)
in_funct3  input  3  funct3 for OP-IMM, OP and JALR (ignored for LOAD and STORE)
in_funct7  input  7  funct7 for OP (ignored otherwise)
in_byte_flag  input  1  LOAD/STORE width: 1 = byte, 0 = word
mem_we  output  1  write strobe
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  encoded instruction
mem_ready  input  1  memory accepts the write this cycle
busy  output  1  state is RUN
done  output  1  state is FULL
err  output  1  sticky error
err_code  output  2  0 = none, 1 = illegal opcode, 2 = immediate not representable
count  output  ADDR_W+1  number of words written since start

Behaviour:
- Reset (asynchronous, rst_n=0) sets: state IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, err_code=0, count=0, in_ready=0.
- States:
  - IDLE: start moves to RUN.
  - RUN: normal operation; moves to FULL when a write is accepted and count reaches 2**ADDR_W.
  - FULL: start moves to RUN.
- start has priority in every state. It discards any pending write, sets mem_we=0, reloads mem_addr to BASE_ADDR, and clears count, err and err_code.
- in_ready = (state==RUN) && !start && (!mem_we || mem_ready).
- A tuple is accepted when in_valid && in_ready.
- Encoding (registered, 1-cycle latency from acceptance to mem_we=1):
  - I-type (OP-IMM, JALR): {imm[11:0], rs1, funct3, rd, opcode}.
  - R-type (OP): {funct7, rs2, rs1, funct3, rd, opcode}.
  - U-type (LUI): {imm[31:12], rd, opcode}.
  - LOAD: I-type layout with funct3 = byte_flag ? 100 : 010.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} with funct3 = byte_flag ? 000 : 010.
- Immediate checks:
  - I and S types require imm[31:11] to be all-equal (valid sign extension).
  - U type requires imm[11:0] == 0.
- Errors:
  - An illegal opcode or a failed immediate check still consumes the tuple, writes nothing and does not advance the address.
  - It sets err=1 and loads err_code. The first error's code is held until start.
- mem_we, mem_addr and mem_wdata hold stable while mem_we && !mem_ready.
- On accepted write (mem_we && mem_ready): mem_addr and count increment. A new tuple may be accepted in the same cycle (back-to-back throughput of 1 word/cycle).
- mem_addr wraps modulo 2**ADDR_W. FULL prevents any write past capacity.
- busy = (state==RUN); done = (state==FULL).

Decomposition:
- Shared package (rv_pkg): opcode localparams (OPC_OPIMM, OPC_JALR, OPC_OP, OPC_LUI, OPC_LOAD, OPC_STORE), funct3 constants for LB/LW/SB/SW, err_code enum, state enum. The existing decoder should import the same opcode constants.
- One combinational sub-module, instr_pack: fields in -> word and error code out. The top level holds the FSM, output register and counters.

Test Plan:
- Bench config: BASE_ADDR=0, ADDR_W=2, mem_ready tied 1 unless stated. Each line: stimulus -> required response.
- Encoding: start, then tuples
  - ADDI x1,x0,5 -> 0x00500093 @0.
  - LUI x2,0x12345000 -> 0x12345137 @1.
  - ADD x5,x6,x7 -> 0x007302B3 @2.
  - SB x3,-4(x2) -> 0xFE310E23 @3.
  - After the 4th write: done=1, count=4, in_ready=0.
- Backpressure: LB x4,8(x1) with mem_ready low for 3 cycles -> 0x0080C203 held stable on mem_wdata. mem_we=1 throughout. in_ready=0. Next tuple is accepted on the mem_ready cycle.
- Errors:
  - opcode 1101111 -> err=1, err_code=1, no mem_we, count unchanged.
  - Then ADDI with imm=0x00000800 -> err_code stays 1.
  - After start, the same ADDI -> err_code=2.
- JALR x1,0(x5) -> 0x000280E7. LUI with imm=0x00000001 -> err_code=2.
- start asserted while mem_we=1 and mem_ready=0 -> mem_we=0 next cycle, mem_addr=0, count=0, state RUN.
- rst_n asserted low mid-stream, asynchronously between clock edges -> all outputs reach their reset values immediately. After release, no write occurs until start.
